noc_resp_tx: RTL
================

NOC_RESP_TX -- requirements
Module: noc_resp_tx

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL: resp_valid  input  1  response request present.
REQ-004 SHALL: resp_ready  output  1  block can accept a request; high only in S_IDLE.
REQ-005 SHALL: resp_type  input  1  0 = read response, 1 = write response.
REQ-006 SHALL: resp_err  input  1  error flag.
REQ-007 SHALL: resp_err_code  input  3  error code.
REQ-008 SHALL: resp_id  input  8  return ID, copied from the originating command's source ID.
REQ-009 SHALL: resp_len  input  3  count of read data bytes, 0..4; values 5..7 saturate to 4.
REQ-010 SHALL: resp_data  input  32  read data.
REQ-011 SHALL: ALE_WRITE  output  1  control-byte marker (CmdR).
REQ-012 SHALL: CMD_WRITE  output  8  byte lane (DataR).
REQ-013 SHALL: tx_busy  output  1  packet in flight (state != S_IDLE).
REQ-014 SHALL: pkt_count  output  8  completed packets, wraps 0xFF->0x00.

Function
REQ-015 SHALL: the outputs form a 9-bit word {ALE_WRITE,CMD_WRITE} that is registered and changes only on the rising edge, so it is stable when the receiver samples on the falling edge.
REQ-016 SHALL: accept a request when resp_valid && resp_ready at a rising edge, and capture all resp_* fields into holding registers in that same edge.
REQ-017 SHALL: emit the code word on the first cycle after acceptance; latency is 1 cycle.
REQ-018 SHALL: the code word is {1'b1, 3'b010, 1'b0, err, err_code} for a read response and {1'b1, 3'b100, 1'b0, err, err_code} for a write response.
REQ-019 SHALL: the FSM states are S_IDLE, S_CODE, S_ID, S_LEN, S_DATA, S_END.
REQ-020 SHALL: the FSM transitions are:
- S_IDLE->S_CODE on accept.
- S_CODE->S_ID.
- S_ID->S_LEN for a read response with err=0; otherwise S_ID->S_END.
- S_LEN->S_DATA if the saturated length is greater than 0; otherwise S_LEN->S_END.
- S_DATA->S_END after the last byte.
- S_END->S_IDLE.
REQ-021 SHALL: in S_ID, drive word {0, resp_id}.
REQ-022 SHALL: in S_LEN, drive word {0, 5'b0, saturated length}.
REQ-023 SHALL: in S_DATA, send the low N bytes of resp_data, most-significant first, each with ALE=0; a 3-bit down-counter tracks the remaining bytes.
REQ-024 SHALL: in S_END, drive 9'h1E0.
REQ-025 SHALL: in S_IDLE, drive 9'h100 continuously.
REQ-026 SHALL: increment pkt_count by 1 on the S_END->S_IDLE transition.
REQ-027 SHALL: packets are separated by at least one idle cycle; resp_ready is low from acceptance through S_END.
REQ-028 SHALL: ignore resp_valid while resp_ready=0; captured fields are unaffected by input changes mid-packet.
REQ-029 SHALL: a packet is never truncated except by reset.

Reset
REQ-030 SHALL: while rst=0, drive state=S_IDLE, {ALE_WRITE,CMD_WRITE}=9'h100, resp_ready=1, tx_busy=0, pkt_count=0x00, and all holding registers and counters =0.
REQ-031 SHALL: reset asserted mid-packet aborts the packet immediately, with no END word and no pkt_count increment.
REQ-032 SHALL: after deassertion, the block can accept on the first rising edge.

Structure
REQ-033 SHALL: opcode nibbles (IDLE 1_000, READ_RESPONSE 1_010, WRITE_RESPONSE 1_100, END 1_111), the FSM state encoding and the maximum data-byte count 4 reside in shared package noc_pkg, which is also used by the command receiver.
REQ-034 SHALL: a single sub-module, noc_byte_sel, performs the combinational byte selection from resp_data by remaining count; all other logic is flat.

Verification
REQ-035 SHALL: read response, id=0x5A, len=2, data=0x11223344, err=0 -> words 0x140, 0x05A, 0x002, 0x033, 0x044, 0x1E0, then 0x100; pkt_count 0->1.
REQ-036 SHALL: write response, id=0x07, err=1, code=5 -> words 0x18D, 0x007, 0x1E0; resp_ready low for 3 cycles after acceptance.
REQ-037 SHALL: read response, err=1, code=2, len=4 -> words 0x14A, id, 0x1E0 (no length or data words).
REQ-038 SHALL: read response, len=7, data=0xDEADBEEF -> length word 0x004, then data words 0x0DE, 0x0AD, 0x0BE, 0x0EF.
REQ-039 SHALL: rst pulsed low during S_DATA -> output 9'h100 asynchronously; pkt_count unchanged; the next request is sent complete.
REQ-040 SHALL: 256 back-to-back write responses with resp_valid held high -> pkt_count wraps to 0x00, and at least one 0x100 word appears between consecutive packets.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: control-byte opcodes, transmitter state encoding,
// and the data-byte limit. The command receiver imports this package too.
package noc_pkg;

    localparam logic [3:0] OP_IDLE       = 4'b1000;
    localparam logic [3:0] OP_READ_RESP  = 4'b1010;
    localparam logic [3:0] OP_WRITE_RESP = 4'b1100;
    localparam logic [3:0] OP_END        = 4'b1111;

    localparam int unsigned MAX_DATA_BYTES = 4;
    localparam logic [2:0]  MAX_LEN        = 3'(MAX_DATA_BYTES);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CODE = 3'd1,
        S_ID   = 3'd2,
        S_LEN  = 3'd3,
        S_DATA = 3'd4,
        S_END  = 3'd5
    } tx_state_e;

    // Control word: {opcode nibble, reserved 0, err, err_code}
    function automatic logic [8:0] ctrl_word(input logic [3:0] op,
                                             input logic       err,
                                             input logic [2:0] code);
        return {op, 1'b0, err, code};
    endfunction

    // Lengths above the byte limit are clamped to it
    function automatic logic [2:0] sat_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

// File: rtl/noc_resp_tx_if.sv
// Response request channel between the response source and noc_resp_tx.
interface noc_resp_tx_if;

    logic        resp_valid;
    logic        resp_ready;
    logic        resp_type;
    logic        resp_err;
    logic [2:0]  resp_err_code;
    logic [7:0]  resp_id;
    logic [2:0]  resp_len;
    logic [31:0] resp_data;

    modport master (
        output resp_valid, resp_type, resp_err, resp_err_code,
               resp_id, resp_len, resp_data,
        input  resp_ready
    );

    modport slave (
        input  resp_valid, resp_type, resp_err, resp_err_code,
               resp_id, resp_len, resp_data,
        output resp_ready
    );

endinterface

// File: rtl/noc_byte_sel.sv
// Picks the next data byte to send given the number of bytes still to go.
// With N remaining, the byte sent is byte N-1 of the word, so the low bytes
// leave most-significant first as the count runs down.
module noc_byte_sel (
    input  logic [31:0] data_i,
    input  logic [2:0]  remain_i,
    output logic [7:0]  byte_o
);

    // Remaining-count to byte-lane mux
    always_comb begin
        byte_o = 8'h00;
        case (remain_i)
            3'd1:    byte_o = data_i[7:0];
            3'd2:    byte_o = data_i[15:8];
            3'd3:    byte_o = data_i[23:16];
            3'd4:    byte_o = data_i[31:24];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/noc_resp_tx.sv
// NoC response transmitter: serialises one accepted response into a stream
// of registered 9-bit words {ALE_WRITE, CMD_WRITE}.
//
// state  | meaning
// S_IDLE | ready for a request, IDLE control word on the lane
// S_CODE | response control word (type, err, err_code)
// S_ID   | return ID byte
// S_LEN  | saturated read length (error-free reads only)
// S_DATA | read data bytes, MSB first, counter holds bytes left
// S_END  | END control word; packet count bumps leaving this state
module noc_resp_tx
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    noc_resp_tx_if.slave       resp,
    output logic               ALE_WRITE,
    output logic [7:0]         CMD_WRITE,
    output logic               tx_busy,
    output logic [7:0]         pkt_count
);

    tx_state_e   state_q, state_d;
    logic        type_q, type_d;
    logic        err_q, err_d;
    logic [2:0]  code_q, code_d;
    logic [7:0]  id_q, id_d;
    logic [2:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [8:0]  word_q, word_d;
    logic [7:0]  pkt_q, pkt_d;
    logic [7:0]  sel_byte;
    logic        accept;

    assign accept          = resp.resp_valid && (state_q == S_IDLE);
    assign resp.resp_ready = (state_q == S_IDLE);
    assign tx_busy         = (state_q != S_IDLE);
    assign {ALE_WRITE, CMD_WRITE} = word_q;
    assign pkt_count       = pkt_q;

    // The byte is chosen from next-cycle values so the data word is registered
    noc_byte_sel u_byte_sel (
        .data_i   (data_d),
        .remain_i (cnt_d),
        .byte_o   (sel_byte)
    );

    // Next-state, field capture and down-counter
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        err_d   = err_q;
        code_d  = code_q;
        id_d    = id_q;
        len_d   = len_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CODE;
                    type_d  = resp.resp_type;
                    err_d   = resp.resp_err;
                    code_d  = resp.resp_err_code;
                    id_d    = resp.resp_id;
                    len_d   = sat_len(resp.resp_len);
                    data_d  = resp.resp_data;
                end
            end
            S_CODE: state_d = S_ID;
            S_ID: begin
                if (!type_q && !err_q) state_d = S_LEN;
                else                   state_d = S_END;
            end
            S_LEN: begin
                if (len_q != 3'd0) begin
                    state_d = S_DATA;
                    cnt_d   = len_q;
                end else begin
                    state_d = S_END;
                end
            end
            S_DATA: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) state_d = S_END;
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output word for the state being entered, so it appears one edge after the decision
    always_comb begin
        word_d = ctrl_word(OP_IDLE, 1'b0, 3'd0);
        unique case (state_d)
            S_CODE:  word_d = ctrl_word(type_d ? OP_WRITE_RESP : OP_READ_RESP, err_d, code_d);
            S_ID:    word_d = {1'b0, id_d};
            S_LEN:   word_d = {1'b0, 5'b0, len_d};
            S_DATA:  word_d = {1'b0, sel_byte};
            S_END:   word_d = ctrl_word(OP_END, 1'b0, 3'd0);
            default: word_d = ctrl_word(OP_IDLE, 1'b0, 3'd0);
        endcase
    end

    // Completed packets counted as the END word retires
    always_comb begin
        pkt_d = pkt_q;
        if (state_q == S_END) pkt_d = pkt_q + 8'd1;
    end

    // State, holding registers and output word
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            type_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 3'd0;
            id_q    <= 8'h00;
            len_q   <= 3'd0;
            data_q  <= 32'h0;
            cnt_q   <= 3'd0;
            word_q  <= ctrl_word(OP_IDLE, 1'b0, 3'd0);
            pkt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            err_q   <= err_d;
            code_q  <= code_d;
            id_q    <= id_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            pkt_q   <= pkt_d;
        end
    end

endmodule
